vga_timing_gen: RTL

Parametrised VGA timing generator. It replaces the fixed 640x480 controller for the display pipeline. From the 100 MHz system clock it produces:
- a pixel-enable strobe;
- pixel coordinates, sync pulses with programmable polarity, and blanking;
- line and frame strobes, plus a running frame counter.

Timing, clock divide ratio and sync polarity are set by parameters. A run/pause enable freezes the raster without losing position. Downstream pixel generators and frame-buffer readers consume x/y/video_on on p_tick.

---
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, x/y coordinates,
// sync/blank decode, line/frame strobes and a frame counter, all registered.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               enable,
  output logic               p_tick,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_tick,
  output logic               refresh_tick,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] Y_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DW-1:0]      div_reg, div_next;
  logic [CW-1:0]      x_reg, x_next;
  logic [CW-1:0]      y_reg, y_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic               p_tick_reg, p_tick_next;
  logic               line_tick_reg, line_tick_next;
  logic               refresh_tick_reg, refresh_tick_next;
  logic               video_on_reg, video_on_next;
  logic               hsync_reg, hsync_next;
  logic               vsync_reg, vsync_next;

  // Divider only moves while enabled, so a pause resumes mid-period without loss.
  always_comb begin
    div_next = div_reg;
    if (enable) begin
      div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
    end
    p_tick_next = enable && (div_next == DIV_LAST);
  end

  // The raster advances at the edge that closes a visible p_tick cycle, so a
  // pixel already presented is consumed even if enable drops at that edge.
  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    frame_next = frame_reg;
    if (p_tick_reg) begin
      if (x_reg == X_LAST) begin
        x_next = '0;
        if (y_reg == Y_LAST) begin
          y_next     = '0;
          frame_next = frame_reg + FRAME_W'(1);
        end else begin
          y_next = y_reg + CW'(1);
        end
      end else begin
        x_next = x_reg + CW'(1);
      end
    end
  end

  // Decode from next-state coordinates so strobes and syncs line up with x/y.
  always_comb begin
    line_tick_next    = p_tick_next && (x_next == X_LAST);
    refresh_tick_next = line_tick_next && (y_next == Y_LAST);
    video_on_next     = (x_next < X_VIS) && (y_next < Y_VIS);
    hsync_next        = ((x_next >= HS_FIRST) && (x_next <= HS_LAST)) ? HS_POL : ~HS_POL;
    vsync_next        = ((y_next >= VS_FIRST) && (y_next <= VS_LAST)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      div_reg          <= '0;
      x_reg            <= '0;
      y_reg            <= '0;
      frame_reg        <= '0;
      p_tick_reg       <= 1'b0;
      line_tick_reg    <= 1'b0;
      refresh_tick_reg <= 1'b0;
      video_on_reg     <= 1'b1;
      hsync_reg        <= ~HS_POL;
      vsync_reg        <= ~VS_POL;
    end else begin
      div_reg          <= div_next;
      x_reg            <= x_next;
      y_reg            <= y_next;
      frame_reg        <= frame_next;
      p_tick_reg       <= p_tick_next;
      line_tick_reg    <= line_tick_next;
      refresh_tick_reg <= refresh_tick_next;
      video_on_reg     <= video_on_next;
      hsync_reg        <= hsync_next;
      vsync_reg        <= vsync_next;
    end
  end

  assign p_tick       = p_tick_reg;
  assign x            = x_reg;
  assign y            = y_reg;
  assign video_on     = video_on_reg;
  assign hsync        = hsync_reg;
  assign vsync        = vsync_reg;
  assign line_tick    = line_tick_reg;
  assign refresh_tick = refresh_tick_reg;
  assign frame_cnt    = frame_reg;

endmodule
